// File: rtl/mips_div_pkg.sv
// Shared definitions for the multi-cycle EX-stage divider: state encodings
// and the handshake constants used by ex/ctrl when driving the divider.
package mips_div_pkg;

  // Divider FSM states; 2-bit encodings are shared with the rest of the pipeline.
  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam int REG_DATA_WIDTH   = 32;
  localparam int DIV_RESULT_WIDTH = 2 * REG_DATA_WIDTH;

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;
  localparam logic ANNUL     = 1'b1;
  localparam logic NOT_ANNUL = 1'b0;

endpackage

// File: rtl/mips_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mips_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic              dividend_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic              quo_bit
);

  // The shifted remainder is always below 2*divisor, so DATA_W+1 bits hold it
  // and the top bit of the DATA_W+1-bit difference is exactly the borrow.
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // Trial subtraction and restore selection.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    diff    = shifted - {1'b0, divisor};
    quo_bit = ~diff[DATA_W];
    rem_out = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
  end

endmodule

// File: rtl/mips_div_seq.sv
// Multi-cycle DIV/DIVU unit for the EX stage. One quotient bit is produced per
// clock; the pipeline is held through stall_req_out until the result is ready.
//
// Handshake: ex raises start_in and holds it (with stable intent) until it sees
// ready_out; operands are captured only on the accepting edge. ready_out stays
// high with result_out held for as long as start_in stays high, and the unit
// returns to IDLE once start_in drops. annul_in cancels at any point and wins
// over a simultaneous start_in.
module mips_div_seq
  import mips_div_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_in,
  input  logic                signed_in,
  input  logic [DATA_W-1:0]   op1_in,
  input  logic [DATA_W-1:0]   op2_in,
  input  logic                annul_in,
  output logic [2*DATA_W-1:0] result_out,
  output logic                ready_out,
  output logic                stall_req_out
);

  div_state_e        state;
  div_state_e        state_next;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] divisor_q;
  logic              quo_neg;
  logic              rem_neg;

  logic              accept;
  logic              last_step;
  logic [DATA_W-1:0] op1_mag;
  logic [DATA_W-1:0] op2_mag;
  logic [DATA_W-1:0] step_rem;
  logic              step_quo;
  logic [DATA_W-1:0] quo_next;
  logic [DATA_W-1:0] quo_fixed;
  logic [DATA_W-1:0] rem_fixed;

  // Operand magnitudes and sign-corrected final values; the magnitude of the
  // most negative value wraps to itself, which is correct read as unsigned.
  always_comb begin
    accept    = start_in & ~annul_in;
    last_step = (cnt == CNT_W'(DATA_W - 1));
    op1_mag   = (signed_in & op1_in[DATA_W-1]) ? (~op1_in + DATA_W'(1)) : op1_in;
    op2_mag   = (signed_in & op2_in[DATA_W-1]) ? (~op2_in + DATA_W'(1)) : op2_in;
    quo_next  = {quo_q[DATA_W-2:0], step_quo};
    quo_fixed = quo_neg ? (~quo_next + DATA_W'(1)) : quo_next;
    rem_fixed = rem_neg ? (~step_rem + DATA_W'(1)) : step_rem;
  end

  mips_div_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .rem_in      (rem_q),
    .dividend_bit(quo_q[DATA_W-1]),
    .divisor     (divisor_q),
    .rem_out     (step_rem),
    .quo_bit     (step_quo)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and stall request.
  always_comb begin
    state_next    = state;
    stall_req_out = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (accept) begin
          stall_req_out = 1'b1;
          state_next    = (op2_in == '0) ? DIV_BYZERO : DIV_ON;
        end
      end
      DIV_BYZERO: begin
        stall_req_out = 1'b1;
        state_next    = annul_in ? DIV_IDLE : DIV_END;
      end
      DIV_ON: begin
        stall_req_out = 1'b1;
        if (annul_in) begin
          state_next = DIV_IDLE;
        end else if (last_step) begin
          state_next = DIV_END;
        end
      end
      DIV_END: begin
        if (!start_in || annul_in) begin
          state_next = DIV_IDLE;
        end
      end
      default: state_next = DIV_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result/ready registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      quo_neg    <= 1'b0;
      rem_neg    <= 1'b0;
      result_out <= '0;
      ready_out  <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          result_out <= '0;
          ready_out  <= 1'b0;
          if (accept && (op2_in != '0)) begin
            quo_q     <= op1_mag;
            divisor_q <= op2_mag;
            rem_q     <= '0;
            cnt       <= '0;
            quo_neg   <= signed_in & (op1_in[DATA_W-1] ^ op2_in[DATA_W-1]);
            rem_neg   <= signed_in & op1_in[DATA_W-1];
          end
        end
        DIV_BYZERO: begin
          result_out <= '0;
          ready_out  <= ~annul_in;
        end
        DIV_ON: begin
          if (annul_in) begin
            cnt        <= '0;
            result_out <= '0;
            ready_out  <= 1'b0;
          end else begin
            rem_q <= step_rem;
            quo_q <= quo_next;
            cnt   <= cnt + CNT_W'(1);
            if (last_step) begin
              result_out <= {rem_fixed, quo_fixed};
              ready_out  <= 1'b1;
            end
          end
        end
        DIV_END: begin
          if (!start_in || annul_in) begin
            result_out <= '0;
            ready_out  <= 1'b0;
          end
        end
        default: begin
          result_out <= '0;
          ready_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_div_seq.sv
// Directed bench for mips_div_seq: a 32-bit instance for the main scenarios and
// an 8-bit instance for the narrow-width case.
module tb_mips_div_seq;
  import mips_div_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sgn;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  logic        start8;
  logic        sgn8;
  logic [7:0]  op1_8;
  logic [7:0]  op2_8;
  logic        annul8;
  logic [15:0] result8;
  logic        ready8;
  logic        stall8;

  int tests_run;
  int tests_failed;

  mips_div_seq #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_in     (start),
    .signed_in    (sgn),
    .op1_in       (op1),
    .op2_in       (op2),
    .annul_in     (annul),
    .result_out   (result),
    .ready_out    (ready),
    .stall_req_out(stall)
  );

  mips_div_seq #(.DATA_W(8)) dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_in     (start8),
    .signed_in    (sgn8),
    .op1_in       (op1_8),
    .op2_in       (op2_8),
    .annul_in     (annul8),
    .result_out   (result8),
    .ready_out    (ready8),
    .stall_req_out(stall8)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: raise start at a falling edge and wait (bounded) for ready.
  // Operands are scrambled after the accepting edge; the unit must ignore that.
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int edges, output int stall_hi, output logic [63:0] res);
    @(negedge clk);
    sgn   = s;
    op1   = a;
    op2   = b;
    start = DIV_START;
    annul = NOT_ANNUL;
    #1;
    stall_hi = stall ? 1 : 0;
    edges    = 0;
    while (edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) begin
        op1 = 32'hDEADBEEF;
        op2 = 32'h0;
      end
      if (ready) break;
      if (stall) stall_hi++;
    end
    res = result;
  endtask

  // Driver: drop start and let one edge pass.
  task automatic end_div();
    @(negedge clk);
    start = DIV_STOP;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (ready !== 1'b0 || result !== 64'h0 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset32: ready=%b result=%h stall=%b, need 0/0/0", ready, result, stall);
    end
    tests_run++;
    if (ready8 !== 1'b0 || result8 !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset8: ready=%b result=%h, need 0/0", ready8, result8);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned_basic();
    int edges, stall_hi;
    logic [63:0] res;
    run_div(1'b0, 32'd100, 32'd7, edges, stall_hi, res);
    tests_run++;
    if (edges != 33) begin
      tests_failed++;
      $display("FAIL udiv_latency: edges=%0d, need 33", edges);
    end
    tests_run++;
    if (stall_hi != 33) begin
      tests_failed++;
      $display("FAIL udiv_stall_cycles: %0d, need 33", stall_hi);
    end
    tests_run++;
    if (res !== 64'h00000002_0000000E) begin
      tests_failed++;
      $display("FAIL udiv_100_7: got %h, need 000000020000000e", res);
    end
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL udiv_stall_end: got %b, need 0", stall);
    end
    // Start still held: result must stay put.
    @(posedge clk);
    #1;
    tests_run++;
    if (ready !== 1'b1 || result !== 64'h00000002_0000000E) begin
      tests_failed++;
      $display("FAIL udiv_hold: ready=%b result=%h, need 1/000000020000000e", ready, result);
    end
    end_div();
    tests_run++;
    if (ready !== 1'b0 || result !== 64'h0) begin
      tests_failed++;
      $display("FAIL udiv_drop: ready=%b result=%h, need 0/0", ready, result);
    end
  endtask

  task automatic test_signed();
    int edges, stall_hi;
    logic [63:0] res;
    run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, edges, stall_hi, res);
    tests_run++;
    if (res !== 64'hFFFFFFFF_FFFFFFFD) begin
      tests_failed++;
      $display("FAIL sdiv_m7_2: got %h, need fffffffffffffffd", res);
    end
    end_div();
    run_div(1'b1, 32'h00000007, 32'hFFFFFFFE, edges, stall_hi, res);
    tests_run++;
    if (res !== 64'h00000001_FFFFFFFD) begin
      tests_failed++;
      $display("FAIL sdiv_7_m2: got %h, need 00000001fffffffd", res);
    end
    end_div();
  endtask

  task automatic test_boundary();
    int edges, stall_hi;
    logic [63:0] res;
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, edges, stall_hi, res);
    tests_run++;
    if (res !== 64'h00000000_80000000) begin
      tests_failed++;
      $display("FAIL sdiv_min_m1: got %h, need 0000000080000000", res);
    end
    end_div();
    run_div(1'b0, 32'hFFFFFFFF, 32'h00000001, edges, stall_hi, res);
    tests_run++;
    if (res !== 64'h00000000_FFFFFFFF) begin
      tests_failed++;
      $display("FAIL udiv_max_1: got %h, need 00000000ffffffff", res);
    end
    end_div();
    // Unsigned treats 0x80000000 / 0xFFFFFFFF as a large divisor.
    run_div(1'b0, 32'h80000000, 32'hFFFFFFFF, edges, stall_hi, res);
    tests_run++;
    if (res !== 64'h80000000_00000000) begin
      tests_failed++;
      $display("FAIL udiv_min_max: got %h, need 8000000000000000", res);
    end
    end_div();
  endtask

  task automatic test_divzero();
    int edges, stall_hi;
    logic [63:0] res;
    run_div(1'b1, 32'd55, 32'd0, edges, stall_hi, res);
    tests_run++;
    if (edges != 2 || ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL divzero_latency: edges=%0d ready=%b, need 2/1", edges, ready);
    end
    tests_run++;
    if (res !== 64'h0 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL divzero_result: result=%h stall=%b, need 0/0", res, stall);
    end
    end_div();
  endtask

  task automatic test_annul();
    int edges, stall_hi, seen;
    logic [63:0] res;
    @(negedge clk);
    sgn   = 1'b0;
    op1   = 32'd1000;
    op2   = 32'd3;
    start = DIV_START;
    annul = NOT_ANNUL;
    // Accept edge plus ten iterations.
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul = ANNUL;
    @(posedge clk);
    #1;
    tests_run++;
    if (ready !== 1'b0 || stall !== 1'b0 || result !== 64'h0) begin
      tests_failed++;
      $display("FAIL annul_on: ready=%b stall=%b result=%h, need 0/0/0", ready, stall, result);
    end
    @(negedge clk);
    annul = NOT_ANNUL;
    start = DIV_STOP;
    seen  = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL annul_no_ready: ready seen %0d cycles, need 0", seen);
    end
    run_div(1'b0, 32'd12, 32'd5, edges, stall_hi, res);
    tests_run++;
    if (res !== 64'h00000002_00000002 || edges != 33) begin
      tests_failed++;
      $display("FAIL annul_restart: result=%h edges=%0d, need 0000000200000002/33", res, edges);
    end
    // Annul while sitting in END with start still high.
    @(negedge clk);
    annul = ANNUL;
    @(posedge clk);
    #1;
    tests_run++;
    if (ready !== 1'b0 || result !== 64'h0) begin
      tests_failed++;
      $display("FAIL annul_end: ready=%b result=%h, need 0/0", ready, result);
    end
    @(negedge clk);
    annul = NOT_ANNUL;
    start = DIV_STOP;
  endtask

  task automatic test_start_annul_idle();
    int seen;
    @(negedge clk);
    sgn   = 1'b0;
    op1   = 32'd9;
    op2   = 32'd0;
    start = DIV_START;
    annul = ANNUL;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_annul_stall: got %b, need 0", stall);
    end
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (ready || stall) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL idle_annul_accept: activity %0d cycles, need 0", seen);
    end
    @(negedge clk);
    start = DIV_STOP;
    annul = NOT_ANNUL;
  endtask

  task automatic test_reset_mid();
    int edges, stall_hi;
    logic [63:0] res;
    @(negedge clk);
    sgn   = 1'b0;
    op1   = 32'd100;
    op2   = 32'd7;
    start = DIV_START;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    start = DIV_STOP;
    @(posedge clk);
    #1;
    tests_run++;
    if (ready !== 1'b0 || result !== 64'h0 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: ready=%b result=%h stall=%b, need 0/0/0", ready, result, stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_div(1'b0, 32'd100, 32'd7, edges, stall_hi, res);
    tests_run++;
    if (res !== 64'h00000002_0000000E || edges != 33) begin
      tests_failed++;
      $display("FAIL reset_mid_rerun: result=%h edges=%0d, need 000000020000000e/33", res, edges);
    end
    end_div();
  endtask

  task automatic test_width8();
    int edges;
    @(negedge clk);
    sgn8   = 1'b0;
    op1_8  = 8'd200;
    op2_8  = 8'd13;
    start8 = DIV_START;
    edges  = 0;
    while (edges < 50) begin
      @(posedge clk);
      #1;
      edges++;
      if (ready8) break;
    end
    tests_run++;
    if (edges != 9) begin
      tests_failed++;
      $display("FAIL w8_latency: edges=%0d, need 9", edges);
    end
    tests_run++;
    if (result8 !== 16'h050F) begin
      tests_failed++;
      $display("FAIL w8_200_13: got %h, need 050f", result8);
    end
    @(negedge clk);
    start8 = DIV_STOP;
    @(posedge clk);
    #1;
    tests_run++;
    if (ready8 !== 1'b0 || result8 !== 16'h0) begin
      tests_failed++;
      $display("FAIL w8_drop: ready=%b result=%h, need 0/0", ready8, result8);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n  = 1'b0;
    start  = DIV_STOP;
    sgn    = 1'b0;
    op1    = '0;
    op2    = '0;
    annul  = NOT_ANNUL;
    start8 = DIV_STOP;
    sgn8   = 1'b0;
    op1_8  = '0;
    op2_8  = '0;
    annul8 = NOT_ANNUL;

    test_reset();
    test_unsigned_basic();
    test_signed();
    test_boundary();
    test_divzero();
    test_annul();
    test_start_annul_idle();
    test_reset_mid();
    test_width8();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
